// File: rtl/uart_boot_loader.sv
// uart_boot_loader: decodes a UART load frame (SYNC, ADDR[4], LEN[2], data, CSUM)
// and writes the payload as 32-bit little-endian words on a valid/ready port.
// An inter-byte timeout aborts a stalled frame, and sticky flags report any error.
// Optional build macro UART_LOADER_ECHO_EN adds an ACK/NAK byte output (o_Tx_DV/o_Tx_Byte).
module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic        i_Clock,
  input  logic        rst_ni,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err_csum,
  output logic        o_err_timeout,
  output logic        o_err_overrun
`ifdef UART_LOADER_ECHO_EN
  ,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte
`endif
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  logic [2:0]  state_reg;
  logic [1:0]  byte_cnt_reg;
  logic [31:0] addr_reg;
  logic [15:0] len_reg;
  logic [31:0] shift_reg;
  logic [7:0]  csum_reg;
  logic [23:0] tmo_cnt_reg;
  logic        wr_valid_reg;
  logic [31:0] wr_addr_reg;
  logic [31:0] wr_data_reg;
  logic        done_reg;
  logic        err_csum_reg;
  logic        err_timeout_reg;
  logic        err_overrun_reg;

  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  logic [31:0] word_next;
  logic [15:0] len_next;
  logic [7:0]  csum_next;
  logic        timeout_hit;
  logic        word_fire;
  logic        overrun_evt;
  logic        csum_ok_evt;
  logic        csum_bad_evt;

  assign word_next    = {i_Rx_Byte, shift_reg[31:8]};
  assign len_next     = {i_Rx_Byte, len_reg[15:8]};
  assign csum_next    = csum_reg + i_Rx_Byte;
  // A byte arriving in the same cycle as the deadline wins over the timeout.
  assign timeout_hit  = (state_reg != ST_IDLE) && !i_Rx_DV && (tmo_cnt_reg == TIMEOUT - 24'd1);
  assign word_fire    = i_Rx_DV && (state_reg == ST_DATA) && (byte_cnt_reg == 2'd3);
  // The previous write only blocks a new word if it is not being accepted this cycle.
  assign overrun_evt  = word_fire && wr_valid_reg && !i_wr_ready;
  assign csum_ok_evt  = i_Rx_DV && (state_reg == ST_CSUM) && (i_Rx_Byte == csum_reg);
  assign csum_bad_evt = i_Rx_DV && (state_reg == ST_CSUM) && (i_Rx_Byte != csum_reg);

  // Inter-byte cycle counter: restarts on every byte and is parked at zero while idle.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni)
      tmo_cnt_reg <= '0;
    else if (state_reg == ST_IDLE || i_Rx_DV)
      tmo_cnt_reg <= '0;
    else
      tmo_cnt_reg <= tmo_cnt_reg + 24'd1;
  end

  // Write port: hold address/data until accepted; a pending write survives frame aborts.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else if (word_fire && !overrun_evt) begin
      wr_valid_reg <= 1'b1;
      wr_addr_reg  <= addr_reg;
      wr_data_reg  <= word_next;
    end else if (wr_valid_reg && i_wr_ready) begin
      wr_valid_reg <= 1'b0;
    end
  end

  // Frame decoder: walks SYNC/ADDR/LEN/DATA/CSUM, accumulates checksum and sets error flags.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= ST_IDLE;
      byte_cnt_reg    <= '0;
      addr_reg        <= '0;
      len_reg         <= '0;
      shift_reg       <= '0;
      csum_reg        <= '0;
      done_reg        <= 1'b0;
      err_csum_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (timeout_hit) begin
        err_timeout_reg <= 1'b1;
        state_reg       <= ST_IDLE;
      end else if (i_Rx_DV) begin
        case (state_reg)
          ST_IDLE: begin
            if (i_Rx_Byte == SYNC_BYTE) begin
              state_reg       <= ST_ADDR;
              byte_cnt_reg    <= '0;
              len_reg         <= '0;
              csum_reg        <= '0;
              err_csum_reg    <= 1'b0;
              err_timeout_reg <= 1'b0;
              err_overrun_reg <= 1'b0;
            end
          end
          ST_ADDR: begin
            csum_reg <= csum_next;
            if (byte_cnt_reg == 2'd3) begin
              addr_reg     <= {i_Rx_Byte, addr_reg[31:10], 2'b00};
              byte_cnt_reg <= '0;
              state_reg    <= ST_LEN;
            end else begin
              addr_reg     <= {i_Rx_Byte, addr_reg[31:8]};
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end
          ST_LEN: begin
            csum_reg <= csum_next;
            len_reg  <= len_next;
            if (byte_cnt_reg == 2'd1) begin
              byte_cnt_reg <= '0;
              state_reg    <= (len_next != 16'd0) ? ST_DATA : ST_CSUM;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
          end
          ST_DATA: begin
            csum_reg  <= csum_next;
            shift_reg <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              if (overrun_evt) begin
                err_overrun_reg <= 1'b1;
                state_reg       <= ST_IDLE;
              end else begin
                addr_reg <= addr_reg + 32'd4;
                len_reg  <= len_reg - 16'd1;
                if (len_reg == 16'd1)
                  state_reg <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (csum_ok_evt)
              done_reg <= 1'b1;
            if (csum_bad_evt)
              err_csum_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_wr_valid    = wr_valid_reg;
  assign o_wr_addr     = wr_addr_reg;
  assign o_wr_data     = wr_data_reg;
  assign o_busy        = (state_reg != ST_IDLE);
  assign o_done        = done_reg;
  assign o_err_csum    = err_csum_reg;
  assign o_err_timeout = err_timeout_reg;
  assign o_err_overrun = err_overrun_reg;

`ifdef UART_LOADER_ECHO_EN
  logic       err_evt_reg;
  logic       tx_dv_reg;
  logic [7:0] tx_byte_reg;

  // ACK coincides with o_done; NAK follows one cycle after the error flag becomes visible.
  always_ff @(posedge i_Clock or negedge rst_ni) begin
    if (!rst_ni) begin
      err_evt_reg <= 1'b0;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= '0;
    end else begin
      err_evt_reg <= timeout_hit || csum_bad_evt || (overrun_evt && !timeout_hit);
      tx_dv_reg   <= csum_ok_evt || err_evt_reg;
      if (csum_ok_evt)
        tx_byte_reg <= 8'h06;
      else if (err_evt_reg)
        tx_byte_reg <= 8'h15;
    end
  end

  assign o_Tx_DV   = tx_dv_reg;
  assign o_Tx_Byte = tx_byte_reg;
`endif

endmodule
